// File: rtl/iperf_client_hls_deadlock_pkg.sv
// Shared types and constants for the iperf_client HLS deadlock report controller.
// Holds the controller state encoding and the saturating event-count helper.
package iperf_client_hls_deadlock_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARM    = 3'd1,
        S_TRACE  = 3'd2,
        S_CLEAR  = 3'd3,
        S_REPORT = 3'd4
    } dl_state_t;

    localparam int DL_CNT_W = 8;
    localparam logic [DL_CNT_W-1:0] DL_CNT_MAX = {DL_CNT_W{1'b1}};

    function automatic logic [DL_CNT_W-1:0] dl_cnt_sat_inc(input logic [DL_CNT_W-1:0] cnt);
        if (cnt == DL_CNT_MAX) begin
            return cnt;
        end
        return cnt + 1'b1;
    endfunction

endpackage

// File: rtl/iperf_client_hls_deadlock_origin_arb.sv
// Lowest-index priority encoder: picks which reporting process becomes the
// traversal origin when several detect units fire together.
module iperf_client_hls_deadlock_origin_arb #(
    parameter int PROC_NUM  = 4,
    parameter int PROC_ID_W = 2
) (
    input  logic [PROC_NUM-1:0]  i_req,
    output logic [PROC_ID_W-1:0] o_id,
    output logic                 o_valid
);

    always_comb begin
        o_id    = '0;
        o_valid = 1'b0;
        // Walk downward so the last hit, i.e. the lowest index, wins.
        for (int i = PROC_NUM - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_id    = PROC_ID_W'(i);
                o_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/iperf_client_hls_deadlock_report_ctrl.sv
// Deadlock report controller: arbitrates an origin, runs one token traversal and
// latches a sticky report. Optional traversal watchdog: IPERF_CLIENT_HLS_DL_WATCHDOG_EN.
module iperf_client_hls_deadlock_report_ctrl
    import iperf_client_hls_deadlock_pkg::*;
#(
    parameter int PROC_NUM  = 4,
    parameter int PROC_ID_W = 2,
    parameter int TIMEOUT   = 64,
    parameter int TIMEOUT_W = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [PROC_NUM-1:0]  dl_detect_vec,
    input  logic [PROC_NUM-1:0]  token_vec,
    input  logic                 dl_ack,
    output logic                 dl_detect_in,
    output logic [PROC_NUM-1:0]  origin_vec,
    output logic                 token_clear,
    output logic                 dl_flag,
    output logic [PROC_ID_W-1:0] dl_proc_id,
    output logic [PROC_NUM-1:0]  dl_proc_set,
    output logic [DL_CNT_W-1:0]  dl_cnt
);

    if (PROC_NUM < 2 || (1 << PROC_ID_W) < PROC_NUM) begin : g_bad_proc_cfg
        $error("PROC_ID_W too narrow for PROC_NUM, or PROC_NUM < 2");
    end
    if (TIMEOUT < 1 || TIMEOUT > (1 << TIMEOUT_W) - 1) begin : g_bad_timeout_cfg
        $error("TIMEOUT must fit in 1..2^TIMEOUT_W-1");
    end

    dl_state_t             r_state;
    dl_state_t             w_state_nxt;
    logic [PROC_ID_W-1:0]  r_org;
    logic [PROC_NUM-1:0]   r_set;
    logic                  r_flag;
    logic [PROC_ID_W-1:0]  r_proc_id;
    logic [PROC_NUM-1:0]   r_proc_set;
    logic [DL_CNT_W-1:0]   r_cnt;

    logic [PROC_ID_W-1:0]  w_arb_id;
    logic                  w_arb_valid;
    logic [PROC_NUM-1:0]   w_org_onehot;
    logic                  w_confirm;
    logic                  w_timeout;

    iperf_client_hls_deadlock_origin_arb #(
        .PROC_NUM  (PROC_NUM),
        .PROC_ID_W (PROC_ID_W)
    ) u_origin_arb (
        .i_req   (dl_detect_vec),
        .o_id    (w_arb_id),
        .o_valid (w_arb_valid)
    );

    assign w_org_onehot = PROC_NUM'(1) << r_org;
    // Only the origin's own detect bit closes the loop; the others are noise here.
    assign w_confirm    = dl_detect_vec[r_org];

`ifdef IPERF_CLIENT_HLS_DL_WATCHDOG_EN
    logic [TIMEOUT_W-1:0] r_wdog;

    assign w_timeout = (r_wdog == TIMEOUT_W'(TIMEOUT));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wdog <= '0;
        end else if (r_state == S_IDLE && w_arb_valid) begin
            r_wdog <= '0;
        end else if (r_state == S_TRACE) begin
            r_wdog <= r_wdog + 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        dl_detect_in = 1'b0;
        origin_vec   = '0;
        token_clear  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_arb_valid) begin
                    w_state_nxt = S_ARM;
                end
            end
            S_ARM: begin
                dl_detect_in = 1'b1;
                origin_vec   = w_org_onehot;
                w_state_nxt  = S_TRACE;
            end
            S_TRACE: begin
                dl_detect_in = 1'b1;
                if (w_confirm || w_timeout) begin
                    token_clear = 1'b1;
                    w_state_nxt = S_CLEAR;
                end
            end
            S_CLEAR: begin
                dl_detect_in = 1'b1;
                token_clear  = 1'b1;
                // The flag can only be set by a confirm in the TRACE just left.
                w_state_nxt  = r_flag ? S_REPORT : S_IDLE;
            end
            S_REPORT: begin
                dl_detect_in = 1'b1;
                token_clear  = 1'b1;
                if (dl_ack) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_org      <= '0;
            r_set      <= '0;
            r_flag     <= 1'b0;
            r_proc_id  <= '0;
            r_proc_set <= '0;
            r_cnt      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_arb_valid) begin
                        r_org <= w_arb_id;
                        r_set <= '0;
                    end
                end
                S_TRACE: begin
                    r_set <= r_set | token_vec;
                    if (w_confirm) begin
                        r_flag     <= 1'b1;
                        r_proc_id  <= r_org;
                        r_proc_set <= r_set | token_vec | w_org_onehot;
                        r_cnt      <= dl_cnt_sat_inc(r_cnt);
                    end
                end
                S_REPORT: begin
                    if (dl_ack) begin
                        r_flag <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign dl_flag     = r_flag;
    assign dl_proc_id  = r_proc_id;
    assign dl_proc_set = r_proc_set;
    assign dl_cnt      = r_cnt;

endmodule
